// File: rtl/interface_fsm_pkg.sv
// -----------------------------------------------------------------------------
// stream_cipher_pkg
//   Types and defaults shared by the stream cipher host interface blocks.
//   interface_state_t is also consumed by `reader`, so its encoding is part of
//   the contract between the two blocks.
// -----------------------------------------------------------------------------
package stream_cipher_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PROCESS,
    IN_ACK,
    OUT_REQ,
    OUT_REL
  } interface_state_t;

  // Cycles allowed in PROCESS before the core is declared stuck.
  localparam int unsigned PROC_TIMEOUT_DEFAULT = 255;

  // Pin synchronizer depth for the asynchronous host handshake inputs.
  localparam int unsigned SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/interface_fsm_if.sv
// -----------------------------------------------------------------------------
// interface_fsm_if
//   Host-side 4-phase handshake pins of the stream cipher.
//   master : the host (drives input_request / output_acknowledge)
//   slave  : interface_fsm (drives input_acknowledge / output_request /
//            output_byte)
// -----------------------------------------------------------------------------
interface interface_fsm_if;

  logic       input_request;
  logic       input_acknowledge;
  logic       output_request;
  logic       output_acknowledge;
  logic [7:0] output_byte;

  modport master (
    output input_request,
    output output_acknowledge,
    input  input_acknowledge,
    input  output_request,
    input  output_byte
  );

  modport slave (
    input  input_request,
    input  output_acknowledge,
    output input_acknowledge,
    output output_request,
    output output_byte
  );

endinterface

// File: rtl/interface_fsm_handshake_sync.sv
// -----------------------------------------------------------------------------
// handshake_sync
//   Multi-flop synchronizer for a single asynchronous level.
//   Ports:
//     clk  : destination clock
//     nrst : asynchronous active-low reset, chain clears to 0
//     i_d  : asynchronous input level
//     o_q  : synchronized level, STAGES cycles behind i_d
// -----------------------------------------------------------------------------
module handshake_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic nrst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the values from before the edge; blocking here would collapse
  // the chain into a single stage.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/interface_fsm.sv
// -----------------------------------------------------------------------------
// interface_fsm
//   Handshake sequencer for the stream cipher. Each byte goes through
//   IDLE -> PROCESS -> IN_ACK and, for data bytes, OUT_REQ -> OUT_REL before
//   returning to IDLE. Key bytes and timed-out bytes skip the output phase.
//
//   Ports:
//     clk              : system clock
//     nrst             : asynchronous active-low reset
//     host             : host handshake pins (slave side of interface_fsm_if)
//     input_byte_pulse : one-cycle capture pulse from reader
//     is_key_pulsed    : 1 = captured byte is a key byte
//     core_done        : one-cycle pulse, core_result valid
//     core_result      : cipher core output byte
//     fsm_state        : registered state, consumed by reader
//     error            : sticky PROCESS timeout flag
// -----------------------------------------------------------------------------
module interface_fsm
  import stream_cipher_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = SYNC_STAGES_DEFAULT,
  parameter int unsigned PROC_TIMEOUT = PROC_TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             nrst,
  interface_fsm_if.slave   host,
  input  logic             input_byte_pulse,
  input  logic             is_key_pulsed,
  input  logic             core_done,
  input  logic [7:0]       core_result,
  output interface_state_t fsm_state,
  output logic             error
);

  localparam int unsigned CNT_W = $clog2(PROC_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(PROC_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  interface_state_t r_state;
  interface_state_t w_next;
  logic             w_timeout;
  logic             w_req_s;
  logic             w_ack_s;
  logic [CNT_W-1:0] r_cnt;
  logic             r_key;
  logic             r_error;
  logic             r_in_ack;
  logic             r_out_req;
  logic [7:0]       r_out_byte;

  // Host pins are asynchronous to clk; only synchronized copies reach the FSM.
  handshake_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk  (clk),
    .nrst (nrst),
    .i_d  (host.input_request),
    .o_q  (w_req_s)
  );

  handshake_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk  (clk),
    .nrst (nrst),
    .i_d  (host.output_acknowledge),
    .o_q  (w_ack_s)
  );

  // NOTE: every signal assigned in this block gets a default before the case,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (input_byte_pulse) w_next = PROCESS;
      end
      PROCESS: begin
        // core_done has priority over a timeout landing on the same cycle.
        if (core_done) begin
          w_next = IN_ACK;
        end else if (r_cnt == CNT_LIMIT) begin
          w_next    = IN_ACK;
          w_timeout = 1'b1;
        end
      end
      IN_ACK: begin
        if (!w_req_s) w_next = (r_key || r_error) ? IDLE : OUT_REQ;
      end
      OUT_REQ: begin
        if (w_ack_s) w_next = OUT_REL;
      end
      OUT_REL: begin
        if (!w_ack_s) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state    <= IDLE;
      r_in_ack   <= 1'b0;
      r_out_req  <= 1'b0;
      r_cnt      <= '0;
      r_key      <= 1'b0;
      r_error    <= 1'b0;
      r_out_byte <= 8'h00;
    end else begin
      r_state   <= w_next;
      // Pin outputs decode the next state so they change on the same edge as
      // fsm_state and come straight from flops.
      r_in_ack  <= (w_next == IN_ACK);
      r_out_req <= (w_next == OUT_REQ);

      unique case (r_state)
        IDLE: begin
          if (input_byte_pulse) begin
            r_key   <= is_key_pulsed;
            r_error <= 1'b0;
            r_cnt   <= '0;
          end
        end
        PROCESS: begin
          if (core_done) begin
            r_out_byte <= core_result;
          end else if (w_timeout) begin
            r_error <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign fsm_state              = r_state;
  assign error                  = r_error;
  assign host.input_acknowledge = r_in_ack;
  assign host.output_request    = r_out_req;
  assign host.output_byte       = r_out_byte;

endmodule

// File: tb/tb_interface_fsm.sv
// -----------------------------------------------------------------------------
// tb_interface_fsm
//   Drives byte transactions through interface_fsm with a behavioural host,
//   reader and core. Expected per-transaction outcomes are queued when a byte
//   is launched and compared when the handshake completes.
// -----------------------------------------------------------------------------
module tb_interface_fsm;
  import stream_cipher_pkg::*;

  localparam int unsigned TB_TIMEOUT = 8;
  localparam int          BUDGET     = 200;

  typedef struct {
    logic [7:0] data;
    logic       out_phase;
    logic       err;
  } exp_t;

  logic             clk = 1'b0;
  logic             nrst = 1'b0;
  logic             input_byte_pulse = 1'b0;
  logic             is_key_pulsed = 1'b0;
  logic             core_done = 1'b0;
  logic [7:0]       core_result = 8'h00;
  interface_state_t fsm_state;
  logic             error;

  interface_fsm_if host_if ();

  interface_fsm #(
    .SYNC_STAGES  (2),
    .PROC_TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clk              (clk),
    .nrst             (nrst),
    .host             (host_if),
    .input_byte_pulse (input_byte_pulse),
    .is_key_pulsed    (is_key_pulsed),
    .core_done        (core_done),
    .core_result      (core_result),
    .fsm_state        (fsm_state),
    .error            (error)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];
  logic [7:0] model_byte = 8'h00;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Host raises its request together with the reader capture pulse.
  task automatic start_txn(input logic key);
    host_if.input_request = 1'b1;
    input_byte_pulse      = 1'b1;
    is_key_pulsed         = key;
    tick();
    input_byte_pulse = 1'b0;
    is_key_pulsed    = 1'b0;
    check("enter_process", fsm_state, PROCESS);
    check("error_cleared", error, 1'b0);
  endtask

  task automatic pulse_done(input logic [7:0] result);
    core_done   = 1'b1;
    core_result = result;
    tick();
    core_done  = 1'b0;
    model_byte = result;
  endtask

  // Plays the host side until the FSM is back in IDLE, then scores the result.
  task automatic finish_txn(input string tag, input bit spurious);
    bit   saw_out = 1'b0;
    bit   done_ok = 1'b0;
    exp_t e;
    for (int i = 0; i < BUDGET; i++) begin
      if (host_if.input_acknowledge && host_if.input_request)
        host_if.input_request = 1'b0;
      if (host_if.output_request && !host_if.output_acknowledge) begin
        if (!saw_out) begin
          saw_out = 1'b1;
          check({tag, "_byte_at_oreq"}, host_if.output_byte, model_byte);
          if (spurious) begin
            input_byte_pulse = 1'b1;
            is_key_pulsed    = 1'b1;
            tick();
            input_byte_pulse = 1'b0;
            is_key_pulsed    = 1'b0;
            check("spur_pulse_state", fsm_state, OUT_REQ);
            check("spur_pulse_byte", host_if.output_byte, model_byte);
          end
        end
        host_if.output_acknowledge = 1'b1;
      end else if (!host_if.output_request && host_if.output_acknowledge) begin
        host_if.output_acknowledge = 1'b0;
      end
      tick();
      if (fsm_state == IDLE && !host_if.input_request && !host_if.output_acknowledge) begin
        done_ok = 1'b1;
        break;
      end
    end
    check({tag, "_completed"}, done_ok, 1'b1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, "_out_phase"}, saw_out, e.out_phase);
      check({tag, "_out_byte"}, host_if.output_byte, e.data);
      check({tag, "_error"}, error, e.err);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cyc;
    bit seen;

    host_if.input_request      = 1'b0;
    host_if.output_acknowledge = 1'b0;

    // Reset values.
    repeat (3) tick();
    check("rst_state", fsm_state, IDLE);
    check("rst_in_ack", host_if.input_acknowledge, 1'b0);
    check("rst_out_req", host_if.output_request, 1'b0);
    check("rst_byte", host_if.output_byte, 8'h00);
    check("rst_error", error, 1'b0);
    nrst = 1'b1;
    repeat (2) tick();

    // Data byte: core_done three cycles after the capture pulse.
    sb_q.push_back('{data: 8'hA5, out_phase: 1'b1, err: 1'b0});
    start_txn(1'b0);
    repeat (2) tick();
    pulse_done(8'hA5);
    check("data_state", fsm_state, IN_ACK);
    check("data_in_ack", host_if.input_acknowledge, 1'b1);
    check("data_byte", host_if.output_byte, 8'hA5);
    check("data_no_oreq", host_if.output_request, 1'b0);
    finish_txn("data", 1'b0);

    // Key byte: no output phase.
    sb_q.push_back('{data: 8'h3C, out_phase: 1'b0, err: 1'b0});
    start_txn(1'b1);
    tick();
    pulse_done(8'h3C);
    check("key_in_ack", host_if.input_acknowledge, 1'b1);
    finish_txn("key", 1'b0);

    // Timeout: IN_ACK exactly TB_TIMEOUT+1 cycles after PROCESS entry.
    sb_q.push_back('{data: 8'h3C, out_phase: 1'b0, err: 1'b1});
    start_txn(1'b0);
    cyc = 0;
    while (fsm_state != IN_ACK && cyc < 50) begin
      tick();
      cyc++;
    end
    check("tmo_cycles", cyc, TB_TIMEOUT + 1);
    check("tmo_error", error, 1'b1);
    check("tmo_byte", host_if.output_byte, 8'h3C);
    finish_txn("tmo", 1'b0);

    // Race: core_done on the timeout cycle wins; start_txn also checks that
    // the previous error is cleared by this pulse.
    sb_q.push_back('{data: 8'h5A, out_phase: 1'b1, err: 1'b0});
    start_txn(1'b0);
    repeat (TB_TIMEOUT) tick();
    pulse_done(8'h5A);
    check("race_state", fsm_state, IN_ACK);
    check("race_error", error, 1'b0);
    check("race_byte", host_if.output_byte, 8'h5A);
    finish_txn("race", 1'b0);

    // core_done while IDLE is ignored.
    core_done   = 1'b1;
    core_result = 8'hFF;
    tick();
    core_done = 1'b0;
    check("spur_done_state", fsm_state, IDLE);
    check("spur_done_byte", host_if.output_byte, 8'h5A);

    // Capture pulse during OUT_REQ is ignored.
    sb_q.push_back('{data: 8'h77, out_phase: 1'b1, err: 1'b0});
    start_txn(1'b0);
    tick();
    pulse_done(8'h77);
    finish_txn("spur", 1'b1);

    // Asynchronous reset while in OUT_REQ.
    start_txn(1'b0);
    tick();
    pulse_done(8'hC3);
    host_if.input_request = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (host_if.output_request) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("rst_mid_reached_oreq", seen, 1'b1);
    #2 nrst = 1'b0;
    #1;
    check("rst_mid_state", fsm_state, IDLE);
    check("rst_mid_in_ack", host_if.input_acknowledge, 1'b0);
    check("rst_mid_out_req", host_if.output_request, 1'b0);
    check("rst_mid_byte", host_if.output_byte, 8'h00);
    check("rst_mid_error", error, 1'b0);
    model_byte = 8'h00;
    tick();
    tick();
    nrst = 1'b1;
    repeat (2) tick();

    // Fresh transaction after reset.
    sb_q.push_back('{data: 8'h96, out_phase: 1'b1, err: 1'b0});
    start_txn(1'b0);
    tick();
    pulse_done(8'h96);
    finish_txn("post_rst", 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/interface_fsm.md
# interface_fsm

Handshake sequencer for the stream cipher: owns the registered `fsm_state` consumed by `reader`. It sequences each byte transaction through capture, core processing, input acknowledge and (for data bytes) a 4-phase output handshake to the host pins. It latches the core result for the output pins and flags a sticky error if the core never finishes.

## Interface
- `SYNC_STAGES`, 2: flop depth of the pin synchronizers on `input_request` and `output_acknowledge` (≥2).
- `PROC_TIMEOUT`, 255: maximum cycles spent in PROCESS waiting for `core_done`; counter width is `$clog2(PROC_TIMEOUT+1)`.

Ports (name, direction, width, meaning):
- `clk` in 1: single system clock.
- `nrst` in 1: asynchronous, active-low reset.
- `input_request` in 1: raw host pin, 4-phase request.
- `output_acknowledge` in 1: raw host pin, 4-phase acknowledge of output.
- `input_byte_pulse` in 1: one-cycle capture pulse from `reader`.
- `is_key_pulsed` in 1: qualifies `input_byte_pulse`; 1 = key byte (no output phase).
- `core_done` in 1: one-cycle pulse from cipher core, result valid.
- `core_result` in 8: cipher core output byte.
- `fsm_state` out `interface_state_t`: current registered state.
- `input_acknowledge` out 1: host pin, 4-phase acknowledge of input.
- `output_request` out 1: host pin, 4-phase output request.
- `output_byte` out 8: registered result presented to host.
- `error` out 1: sticky PROCESS timeout flag.

## Operation
- `req_s`, `ack_s` = synchronized `input_request` and `output_acknowledge`. All decisions use the synchronized versions only.
- IDLE:
  - On `input_byte_pulse`: latch `is_key_pulsed` into `key_r`, clear `error`, clear the timeout counter, go to PROCESS.
  - `input_byte_pulse` is ignored in all other states.
- PROCESS:
  - On `core_done`: `output_byte <= core_result`, go to IN_ACK.
  - Otherwise the counter increments. When it reaches `PROC_TIMEOUT`, set `error`, leave `output_byte` unchanged, and go to IN_ACK.
  - If `core_done` and the timeout occur in the same cycle, `core_done` wins and `error` is not set.
  - `core_done` outside PROCESS is ignored.
- IN_ACK: `input_acknowledge` = 1. When `req_s` = 0:
  - If `key_r` or `error`, go to IDLE.
  - Otherwise go to OUT_REQ.
- OUT_REQ: `output_request` = 1. When `ack_s` = 1, go to OUT_REL.
- OUT_REL: `output_request` = 0. When `ack_s` = 0, go to IDLE.
- `input_acknowledge` and `output_request` are registered Moore outputs decoded from the next state, so they are glitch-free on the pins.
- `output_byte` holds its value until the next `core_done` in PROCESS.
- `error` holds until the next accepted `input_byte_pulse` or reset.

## Timing
- Reset (async assert, sync release):
  - `fsm_state` = IDLE.
  - `input_acknowledge`, `output_request`, `error` = 0.
  - `output_byte` = 8'h00; counter = 0; `key_r` = 0.
- Reset asserted mid-transaction aborts immediately to IDLE, with no handshake completion.
- Pin-to-decision latency is `SYNC_STAGES` cycles; pin-to-output response is `SYNC_STAGES`+1 cycles.
- `input_byte_pulse` (cycle N) leads to `fsm_state` = PROCESS at N+1.
- `core_done` (cycle M) leads to `input_acknowledge` = 1 and new `output_byte` at M+1. The output byte is stable before `output_request` rises.
- Timeout: IN_ACK is entered exactly `PROC_TIMEOUT`+1 cycles after PROCESS entry when no `core_done` arrives.
- Host protocol violations (request dropped early, ack without request) cause no state skip. The FSM waits only on the level it expects.

## Structure
- `stream_cipher_pkg` holds:
  - `typedef enum logic [2:0] interface_state_t {IDLE, PROCESS, IN_ACK, OUT_REQ, OUT_REL}`, shared with `reader`.
  - Default `PROC_TIMEOUT`.
- Sub-module `handshake_sync`: a parameterized `SYNC_STAGES` flop chain, with async active-low reset to 0. Instantiate it twice.

## Test plan
- Data byte: pulse with `is_key_pulsed`=0, `core_done` 3 cycles later with `core_result`=8'hA5. Required: `input_acknowledge` high, then `output_byte`=8'hA5 with `output_request` high; host ack high→low returns the FSM to IDLE.
- Key byte: pulse with `is_key_pulsed`=1, `core_done` with 8'h3C. Required: `input_acknowledge` pulses through the 4-phase exchange, `output_request` stays 0, `output_byte`=8'h3C, and the FSM returns to IDLE.
- Timeout: `PROC_TIMEOUT`=8, no `core_done`. Required: `error`=1 and IN_ACK entered 9 cycles after PROCESS, no output phase, `output_byte` unchanged. The next pulse clears `error`.
- Race: `core_done` on exactly the timeout cycle with 8'h5A. Required: `error`=0, `output_byte`=8'h5A.
- Spurious inputs: `input_byte_pulse` during OUT_REQ and `core_done` during IDLE. Required: no state or `output_byte` change.
- Reset in OUT_REQ. Required: all outputs return to reset values asynchronously and `fsm_state`=IDLE. A fresh transaction afterwards completes normally.
